// File: rtl/riscv_base_div_issue_pkg.sv
// Shared encodings for the divide issue block: RV32M opcode fields and FSM states.
// The decode helper is the single definition of which instruction words count as a divide.
package riscv_base_div_issue_pkg;

  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;
  localparam logic [2:0] F3_DIV        = 3'b100;
  localparam logic [2:0] F3_DIVU       = 3'b101;
  localparam logic [2:0] F3_REM        = 3'b110;
  localparam logic [2:0] F3_REMU       = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

  function automatic logic is_divide(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == FUNCT7_MULDIV) &&
           (insn[14:12] inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
  endfunction

endpackage

// File: rtl/riscv_base_div_issue_timeout.sv
// Loadable up-counter that flags a divider hang. expired_o is raised in the
// last enabled cycle before the count would reach TIMEOUT_CYCLES.
module riscv_base_div_issue_timeout #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/riscv_base_div_issue.sv
// Issue side of the iterative divider: decodes, launches, stalls the pipeline,
// and forwards the divider result to the register file.
module riscv_base_div_issue
  import riscv_base_div_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic [31:0] issue_ra_operand_i,
  input  logic [31:0] issue_rb_operand_i,
  input  logic        flush_i,
  output logic        issue_accept_o,
  output logic        stall_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic        div_opcode_valid_o,
  output logic        div_opcode_invalid_o,
  output logic [31:0] div_opcode_opcode_o,
  output logic [31:0] div_opcode_pc_o,
  output logic [4:0]  div_opcode_rd_idx_o,
  output logic [4:0]  div_opcode_ra_idx_o,
  output logic [4:0]  div_opcode_rb_idx_o,
  output logic [31:0] div_opcode_ra_operand_o,
  output logic [31:0] div_opcode_rb_operand_o,
  input  logic        div_writeback_valid_i,
  input  logic [31:0] div_writeback_value_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_data_o
);

  // Handshake: an instruction transfers in any cycle where issue_valid_i and
  // issue_accept_o are both high; the execute stage must hold it until then.
  div_state_e  state_q;
  logic        stall_q, illegal_q, timeout_q, valid_q, invalid_q;
  logic [31:0] opcode_q, pc_q, ra_op_q, rb_op_q;
  logic [4:0]  rd_q, ra_q, rb_q;
  logic        rf_wr_en_q;
  logic [4:0]  rf_wr_idx_q;
  logic [31:0] rf_wr_data_q;
  logic        expired;

  assign issue_accept_o = (state_q == ST_IDLE) && issue_valid_i && !flush_i;

  // The counter is cleared while leaving ISSUE so WAIT and a direct DRAIN both start from zero.
  riscv_base_div_issue_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (state_q == ST_ISSUE),
    .en_i     ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      stall_q      <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
      invalid_q    <= 1'b0;
      opcode_q     <= '0;
      pc_q         <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      ra_op_q      <= '0;
      rb_op_q      <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_idx_q  <= '0;
      rf_wr_data_q <= '0;
    end else begin
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (issue_accept_o) begin
            if (is_divide(issue_opcode_i)) begin
              opcode_q <= issue_opcode_i;
              pc_q     <= issue_pc_i;
              rd_q     <= issue_rd_idx_i;
              ra_q     <= issue_ra_idx_i;
              rb_q     <= issue_rb_idx_i;
              ra_op_q  <= issue_ra_operand_i;
              rb_op_q  <= issue_rb_operand_i;
              valid_q  <= 1'b1;
              stall_q  <= 1'b1;
              state_q  <= ST_ISSUE;
            end else begin
              invalid_q <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: state_q <= flush_i ? ST_DRAIN : ST_WAIT;
        ST_WAIT: begin
          if (div_writeback_valid_i) begin
            // A flush in the same cycle as the result wins: the result is dropped.
            if (!flush_i && (rd_q != 5'd0)) begin
              rf_wr_en_q   <= 1'b1;
              rf_wr_idx_q  <= rd_q;
              rf_wr_data_q <= div_writeback_value_i;
            end
            stall_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (expired) begin
            timeout_q <= 1'b1;
            stall_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (flush_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (div_writeback_valid_i) begin
            stall_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (expired) begin
            timeout_q <= 1'b1;
            stall_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o                 = stall_q;
  assign illegal_o               = illegal_q;
  assign timeout_o               = timeout_q;
  assign div_opcode_valid_o      = valid_q;
  assign div_opcode_invalid_o    = invalid_q;
  assign div_opcode_opcode_o     = opcode_q;
  assign div_opcode_pc_o         = pc_q;
  assign div_opcode_rd_idx_o     = rd_q;
  assign div_opcode_ra_idx_o     = ra_q;
  assign div_opcode_rb_idx_o     = rb_q;
  assign div_opcode_ra_operand_o = ra_op_q;
  assign div_opcode_rb_operand_o = rb_op_q;
  assign rf_wr_en_o              = rf_wr_en_q;
  assign rf_wr_idx_o             = rf_wr_idx_q;
  assign rf_wr_data_o            = rf_wr_data_q;

endmodule

// File: tb/tb_riscv_base_div_issue.sv
// Bench for riscv_base_div_issue: a behavioural divider stub answers launches,
// expected launches / writes / pulses are queued by the driver and checked by a monitor.
module tb_riscv_base_div_issue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [31:0] issue_opcode_i = '0, issue_pc_i = '0;
  logic [4:0]  issue_rd_idx_i = '0, issue_ra_idx_i = '0, issue_rb_idx_i = '0;
  logic [31:0] issue_ra_operand_i = '0, issue_rb_operand_i = '0;
  logic        flush_i = 1'b0;
  logic        issue_accept_o, stall_o, illegal_o, timeout_o;
  logic        div_opcode_valid_o, div_opcode_invalid_o;
  logic [31:0] div_opcode_opcode_o, div_opcode_pc_o;
  logic [4:0]  div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o;
  logic [31:0] div_opcode_ra_operand_o, div_opcode_rb_operand_o;
  logic        div_writeback_valid_i = 1'b0;
  logic [31:0] div_writeback_value_i = '0;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_data_o;

  riscv_base_div_issue #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_opcode_i(issue_opcode_i), .issue_pc_i(issue_pc_i),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_ra_idx_i(issue_ra_idx_i), .issue_rb_idx_i(issue_rb_idx_i),
    .issue_ra_operand_i(issue_ra_operand_i), .issue_rb_operand_i(issue_rb_operand_i),
    .flush_i(flush_i), .issue_accept_o(issue_accept_o), .stall_o(stall_o),
    .illegal_o(illegal_o), .timeout_o(timeout_o),
    .div_opcode_valid_o(div_opcode_valid_o), .div_opcode_invalid_o(div_opcode_invalid_o),
    .div_opcode_opcode_o(div_opcode_opcode_o), .div_opcode_pc_o(div_opcode_pc_o),
    .div_opcode_rd_idx_o(div_opcode_rd_idx_o), .div_opcode_ra_idx_o(div_opcode_ra_idx_o),
    .div_opcode_rb_idx_o(div_opcode_rb_idx_o),
    .div_opcode_ra_operand_o(div_opcode_ra_operand_o), .div_opcode_rb_operand_o(div_opcode_rb_operand_o),
    .div_writeback_valid_i(div_writeback_valid_i), .div_writeback_value_i(div_writeback_value_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_data_o(rf_wr_data_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b100:  ref_div = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'b101:  ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  ref_div = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_div_word(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h01) && w[14];
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_op_q[$];
  logic [31:0] exp_pc_q[$];
  logic [14:0] exp_idx_q[$];
  logic [63:0] exp_ops_q[$];
  logic [36:0] exp_rf_q[$];
  logic [0:0]  exp_ill_q[$];
  logic [0:0]  exp_to_q[$];

  // ---------------- divider stub ----------------
  int stub_lat = 4;
  bit stub_hang = 1'b0;

  initial begin
    logic [31:0] res;
    forever begin
      @(negedge clk_i);
      if (!rst_i && div_opcode_valid_o && !stub_hang) begin
        res = ref_div(div_opcode_opcode_o[14:12], div_opcode_ra_operand_o, div_opcode_rb_operand_o);
        repeat (stub_lat - 1) @(posedge clk_i);
        #1;
        div_writeback_valid_i = 1'b1;
        div_writeback_value_i = res;
        @(posedge clk_i);
        #1;
        div_writeback_valid_i = 1'b0;
        div_writeback_value_i = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_wb;
    logic [36:0] e;
    prev_wb = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_wb = 1'b0;
      end else begin
        if (div_opcode_valid_o) begin
          chk("launch_expected", 64'(exp_op_q.size() != 0), 64'd1);
          if (exp_op_q.size() != 0) begin
            chk("launch_opcode", div_opcode_opcode_o, exp_op_q.pop_front());
            chk("launch_pc", div_opcode_pc_o, exp_pc_q.pop_front());
            chk("launch_idx", {div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o}, exp_idx_q.pop_front());
            chk("launch_operands", {div_opcode_ra_operand_o, div_opcode_rb_operand_o}, exp_ops_q.pop_front());
          end
        end
        if (illegal_o || div_opcode_invalid_o) begin
          chk("illegal_invalid_pair", illegal_o, div_opcode_invalid_o);
          chk("illegal_expected", 64'(exp_ill_q.size() != 0), 64'd1);
          if (exp_ill_q.size() != 0) void'(exp_ill_q.pop_front());
        end
        if (timeout_o) begin
          chk("timeout_expected", 64'(exp_to_q.size() != 0), 64'd1);
          if (exp_to_q.size() != 0) void'(exp_to_q.pop_front());
        end
        if (rf_wr_en_o) begin
          chk("rf_wr_expected", 64'(exp_rf_q.size() != 0), 64'd1);
          chk("rf_wr_latency", prev_wb, 1'b1);
          if (exp_rf_q.size() != 0) begin
            e = exp_rf_q.pop_front();
            chk("rf_wr_idx", rf_wr_idx_o, e[36:32]);
            chk("rf_wr_data", rf_wr_data_o, e[31:0]);
          end
        end
        if ((int'(rf_wr_en_o) + int'(illegal_o) + int'(timeout_o)) > 1)
          chk("pulse_exclusive", {rf_wr_en_o, illegal_o, timeout_o}, 3'b000);
        prev_wb = div_writeback_valid_i;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state(input string tag);
    chk({tag, "_strobes"}, {stall_o, illegal_o, timeout_o, div_opcode_valid_o, div_opcode_invalid_o, rf_wr_en_o}, 0);
    chk({tag, "_op_pc"}, {div_opcode_opcode_o, div_opcode_pc_o}, 0);
    chk({tag, "_operands"}, {div_opcode_ra_operand_o, div_opcode_rb_operand_o}, 0);
    chk({tag, "_idx_rf"}, {div_opcode_rd_idx_o, div_opcode_ra_idx_o, div_opcode_rb_idx_o, rf_wr_idx_o, rf_wr_data_o}, 0);
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic [31:0] op, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue_opcode_i = op; issue_pc_i = pc; issue_rd_idx_i = rd;
    issue_ra_idx_i = ra; issue_rb_idx_i = rb;
    issue_ra_operand_i = a; issue_rb_operand_i = b;
    issue_valid_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!issue_accept_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("issue_accept", issue_accept_o, 1'b1);
    @(posedge clk_i);
    #1;
    issue_valid_i = 1'b0;
    issue_opcode_i = $urandom;
    issue_ra_operand_i = $urandom;
  endtask

  task automatic wait_stall_low();
    int n;
    n = 0;
    while (stall_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("stall_release", stall_o, 1'b0);
  endtask

  // flush_at=0: no flush; otherwise flush is sampled flush_at edges after the accepting edge.
  task automatic do_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int flush_at, input bit hang);
    logic [31:0] op, pc;
    logic [4:0] ra, rb;
    int n;
    ra = 5'($urandom); rb = 5'($urandom); pc = $urandom & 32'hFFFF_FFFC;
    op = {7'h01, rb, ra, f3, rd, 7'h33};
    stub_lat = lat;
    stub_hang = hang;
    exp_op_q.push_back(op); exp_pc_q.push_back(pc);
    exp_idx_q.push_back({rd, ra, rb}); exp_ops_q.push_back({a, b});
    if (!hang && rd != 0 && (flush_at == 0 || flush_at > lat))
      exp_rf_q.push_back({rd, ref_div(f3, a, b)});
    if (hang) exp_to_q.push_back(1'b1);
    issue(op, pc, rd, ra, rb, a, b);
    @(negedge clk_i);
    chk("stall_after_accept", stall_o, 1'b1);
    if (hang) begin
      n = 0;
      while (!timeout_o && n < 200) begin
        @(negedge clk_i);
        n++;
      end
      chk("timeout_latency", n, 65);
      chk("stall_after_timeout", stall_o, 1'b0);
    end else if (flush_at > 0) begin
      repeat (flush_at - 1) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      @(negedge clk_i);
    end
    wait_stall_low();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic do_illegal(input logic [31:0] w);
    exp_ill_q.push_back(1'b1);
    issue(w, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
    @(negedge clk_i);
    chk("illegal_pulse", illegal_o, 1'b1);
    chk("illegal_no_stall", stall_o, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w, a, b;
    logic [2:0] f3;
    int lat, fl;
    #1 rst_i = 1'b1;
    #1 check_reset_state("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    do_div(3'b100, 32'h0000_000F, 32'h0000_0003, 5'd5, 6, 0, 1'b0);
    do_div(3'b111, 32'h0000_000F, 32'h0000_0000, 5'd0, 4, 0, 1'b0);
    do_div(3'b101, 32'hFFFF_FFF1, 32'h0000_0003, 5'd7, 5, 0, 1'b0);
    do_illegal(32'h0000_4033);
    do_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 10, 3, 1'b0);
    do_div(3'b100, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 5'd11, 3, 0, 1'b0);
    do_div(3'b100, 32'h0000_0064, 32'h0000_0007, 5'd12, 5, 5, 1'b0);
    do_div(3'b101, 32'h0000_0064, 32'h0000_0007, 5'd13, 5, 1, 1'b0);
    do_div(3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 5'd14, 20, 0, 1'b1);
    do_div(3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 5'd14, 3, 0, 1'b0);

    // Reset in the middle of WAIT with a divider that never answers.
    stub_hang = 1'b1;
    exp_op_q.push_back(32'h0200_C2B3); exp_pc_q.push_back(32'h100);
    exp_idx_q.push_back({5'd5, 5'd1, 5'd2}); exp_ops_q.push_back({32'd50, 32'd5});
    issue(32'h0200_C2B3, 32'h100, 5'd5, 5'd1, 5'd2, 32'd50, 32'd5);
    repeat (10) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 check_reset_state("midwait_reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (90) @(posedge clk_i);
    #1;
    chk("idle_after_reset_accept", issue_accept_o, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 1) w = {7'h01, w[24:15], 1'b0, w[13:7], 7'h33};
        if (is_div_word(w)) w[14] = 1'b0;
        do_illegal(w);
      end else begin
        f3 = 3'b100 | 3'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
          0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          1: begin a = $urandom; b = 32'h0; end
          2: begin a = $urandom; b = $urandom_range(1, 17); end
          default: begin a = $urandom; b = $urandom; end
        endcase
        lat = $urandom_range(2, 10);
        fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 2) : 0;
        do_div(f3, a, b, 5'($urandom_range(0, 31)), lat, fl, 1'b0);
      end
    end

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("launch_q_empty", exp_op_q.size(), 0);
    chk("rf_q_empty", exp_rf_q.size(), 0);
    chk("illegal_q_empty", exp_ill_q.size(), 0);
    chk("timeout_q_empty", exp_to_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/riscv_base_div_issue.md
Name: riscv_base_div_issue

Overview:
- Issue-side counterpart of riscv_base_divider.
- Accepts a decoded M-extension divide instruction from the execute stage and drives the divider's opcode interface with a one-cycle launch pulse.
- Stalls the pipeline while the divide is outstanding, then captures the divider writeback and forwards it to the register-file write port.
- Also handles illegal encodings, pipeline flush of an in-flight divide, and a divider-hang timeout.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in WAIT/DRAIN without div_writeback_valid_i before timeout_o fires.
- CNT_W, 7: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; single clock domain, all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- issue_valid_i  in  1  execute stage presents an instruction.
- issue_opcode_i  in  32  raw instruction word.
- issue_pc_i  in  32  instruction PC.
- issue_rd_idx_i / issue_ra_idx_i / issue_rb_idx_i  in  5 each  register indices.
- issue_ra_operand_i / issue_rb_operand_i  in  32 each  source operand values.
- flush_i  in  1  pipeline flush; kill the outstanding divide.
- issue_accept_o  out  1  instruction taken this cycle (combinational).
- stall_o  out  1  hold the pipeline (registered).
- illegal_o  out  1  one-cycle pulse: accepted word is not a divide.
- timeout_o  out  1  one-cycle pulse: divider failed to respond.
- div_opcode_valid_o  out  1  one-cycle launch pulse to the divider.
- div_opcode_invalid_o  out  1  one-cycle pulse for illegal words.
- div_opcode_opcode_o / div_opcode_pc_o  out  32 each  registered copies.
- div_opcode_rd_idx_o / div_opcode_ra_idx_o / div_opcode_rb_idx_o  out  5 each  registered copies.
- div_opcode_ra_operand_o / div_opcode_rb_operand_o  out  32 each  registered copies.
- div_writeback_valid_i  in  1  divider result strobe (one cycle).
- div_writeback_value_i  in  32  divider result.
- rf_wr_en_o  out  1  register-file write strobe.
- rf_wr_idx_o  out  5  destination register.
- rf_wr_data_o  out  32  write data.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, all outputs 0, held captured fields 0, timeout counter 0.
- Divide class = opcode[6:0]==0x33 && funct7[31:25]==0x01 && funct3[14]==1 (DIV/DIVU/REM/REMU).
- issue_accept_o = (state==IDLE) & issue_valid_i & ~flush_i.

State machine:
- IDLE: on accept of a divide-class word, register all issue_* fields into div_opcode_* and go to ISSUE.
- IDLE: on accept of a non-divide word, pulse div_opcode_invalid_o and illegal_o next cycle; no launch, no rf write; stay IDLE.
- ISSUE (1 cycle): div_opcode_valid_o=1. Go to WAIT, or to DRAIN if flush_i.
- WAIT: clear the timeout counter on entry, then increment every cycle.
  - div_writeback_valid_i & ~flush_i: next cycle rf_wr_en_o=1 only if rd!=0, with rf_wr_idx_o=held rd and rf_wr_data_o=div_writeback_value_i; go to IDLE.
  - flush_i & div_writeback_valid_i in the same cycle: flush wins, result discarded, go to IDLE.
  - flush_i alone: go to DRAIN.
  - Counter reaches TIMEOUT_CYCLES: pulse timeout_o, no write, go to IDLE.
- DRAIN: the divider cannot be cancelled, so wait for div_writeback_valid_i, discard it, go to IDLE. Same timeout rule as WAIT.
- stall_o registered: 1 in ISSUE, WAIT and DRAIN; 0 in IDLE. This makes it high the cycle after accept.
- div_opcode_* data fields hold their last values until the next accept; only the valid/invalid strobes pulse.

Latency:
- Accept at cycle N → launch pulse at N+1.
- Writeback strobe at cycle M → rf_wr_en_o at M+1.
- Total = divider latency + 2.
- rf_wr_en_o, illegal_o, timeout_o: exactly one-cycle pulses, mutually exclusive.

Reset mid-operation: immediate return to IDLE; no write, no pulse. The divider shares rst_i.

Decomposition:
- Add to riscv_base_defines.v: OPC_OP (7'h33), FUNCT7_MULDIV (7'h01), the divide funct3 codes, and the state encodings IDLE/ISSUE/WAIT/DRAIN.
- Sub-module riscv_base_div_timeout (loadable counter with expiry flag), instantiated once.
- Decode and FSM stay in the top block.

Test Plan:
- DIV 0x0000000F/0x00000003, rd=5, with riscv_base_divider attached → one launch pulse; stall_o high until rf_wr_en_o=1, rf_wr_idx_o=5, rf_wr_data_o=0x00000005; then stall_o=0.
- REMU 0x0000000F/0x00000000, rd=0 → writeback received, rf_wr_en_o stays 0, return to IDLE; next DIVU 0xFFFFFFF1/3, rd=7 writes 0x55555550.
- Issue 0x00004033 (XOR) → illegal_o and div_opcode_invalid_o pulse once; no launch; stall_o stays 0.
- DIV 0x80000000/0xFFFFFFFF, flush_i asserted 3 cycles after launch → DRAIN; writeback discarded, no rf write; next DIV -15/-3 writes 0x00000005.
- Stub divider never responds, TIMEOUT_CYCLES=64 → timeout_o pulses exactly 64 cycles after entering WAIT; state returns to IDLE; issue_accept_o works again.
- rst_i asserted mid-WAIT → all outputs 0 asynchronously; no rf write after release.
